regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// -----------------------------------------------------------------------------
// Register file with two combinational read ports, two write ports and a
// per-register busy scoreboard for tracking outstanding loads.
//
// Handshake: there is no valid/ready flow control. issue_en is a request that
// takes effect on the next rising edge only when issue_ready is high in the
// same cycle. When issue_ready is low the request is dropped and
// err_reissue pulses the following cycle.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_addr1/2  -> rd_data1/2   read ports, bypassed from same-cycle writes
//   rd_busy1/2                  addressed register has a pending load
//   wa_en/wa_addr/wa_data       write port A (ALU result), higher priority
//   wb_en/wb_addr/wb_data       write port B (load writeback), clears busy
//   issue_en/issue_addr         mark destination busy (load issued)
//   issue_ready                 issue_addr is not busy (wb-bypassed)
//   busy_vec, busy_cnt          registered busy bits and their popcount
//   err_wr_conflict             pulse: wa and wb hit the same register
//   err_reissue                 pulse: issue to a register already busy
// Register 0 is hardwired to zero and can never be marked busy.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic                   rd_busy1,
    output logic                   rd_busy2,
    input  logic                   wa_en,
    input  logic [ADDR_W-1:0]      wa_addr,
    input  logic [DATA_W-1:0]      wa_data,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    output logic                   issue_ready,
    output logic [(1<<ADDR_W)-1:0] busy_vec,
    output logic [ADDR_W:0]        busy_cnt,
    output logic                   err_wr_conflict,
    output logic                   err_reissue
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_conf_q, err_conf_d;
    logic              err_re_q, err_re_d;

    logic wa_hit, wb_hit, issue_fire;

    assign wa_hit = wa_en && (wa_addr != '0);
    assign wb_hit = wb_en && (wb_addr != '0);

    // Read bypass: port A beats port B beats stored value; r0 is always zero.
    assign rd_data1 = (rd_addr1 == '0)                 ? '0      :
                      (wa_en && (wa_addr == rd_addr1)) ? wa_data :
                      (wb_en && (wb_addr == rd_addr1)) ? wb_data :
                                                         regs_q[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0)                 ? '0      :
                      (wa_en && (wa_addr == rd_addr2)) ? wa_data :
                      (wb_en && (wb_addr == rd_addr2)) ? wb_data :
                                                         regs_q[rd_addr2];

    // A writeback arriving this cycle already counts as having cleared busy.
    assign rd_busy1    = busy_q[rd_addr1]   && !(wb_en && (wb_addr == rd_addr1));
    assign rd_busy2    = busy_q[rd_addr2]   && !(wb_en && (wb_addr == rd_addr2));
    assign issue_ready = !(busy_q[issue_addr] && !(wb_en && (wb_addr == issue_addr)));
    assign issue_fire  = issue_en && issue_ready && (issue_addr != '0);

    always_comb begin
        regs_d = regs_q;
        // Port B first so port A overwrites it on an address conflict.
        if (wb_hit) regs_d[wb_addr] = wb_data;
        if (wa_hit) regs_d[wa_addr] = wa_data;
    end

    always_comb begin
        busy_d = busy_q;
        // Clear before set: a same-cycle issue to the written-back register wins.
        if (wb_en)      busy_d[wb_addr]    = 1'b0;
        if (issue_fire) busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // The count tracks the next busy vector so the two registers agree every cycle.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    assign err_conf_d = wa_hit && wb_en && (wa_addr == wb_addr);
    assign err_re_d   = issue_en && !issue_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            cnt_q      <= '0;
            err_conf_q <= 1'b0;
            err_re_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            err_conf_q <= err_conf_d;
            err_re_q   <= err_re_d;
        end
    end

    assign busy_vec        = busy_q;
    assign busy_cnt        = cnt_q;
    assign err_wr_conflict = err_conf_q;
    assign err_reissue     = err_re_q;

endmodule
